// File: rtl/bsg_strobe_multi.sv
//------------------------------------------------------------------------------
// bsg_strobe_multi : multi-channel programmable periodic / one-shot strobe
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_strobe_multi #(
    parameter int channels_p     = 4,
    parameter int width_p        = 16,
    parameter int lg_channels_lp = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cfg_v_i,
    output logic                      cfg_ready_o,
    input  logic [lg_channels_lp-1:0] cfg_chan_i,
    input  logic [width_p-1:0]        cfg_period_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_oneshot_i,
    input  logic                      sync_i,
    output logic [channels_p-1:0]     strobe_r_o,
    output logic [channels_p-1:0]     active_o
);

    logic cfg_fire;

    assign cfg_ready_o = reset_n_i;
    assign cfg_fire    = cfg_v_i & cfg_ready_o;

    for (genvar g = 0; g < channels_p; g++) begin : g_chan
        localparam logic [lg_channels_lp-1:0] c_idx = lg_channels_lp'(g);

        logic [width_p-1:0] period_q, period_d;
        logic [width_p-1:0] cnt_q, cnt_d;
        logic               en_q, en_d;
        logic               oneshot_q, oneshot_d;
        logic               strobe_q, strobe_d;
        logic               wr;

        // Out-of-range indices never match any channel, so they are dropped.
        assign wr = cfg_fire && (cfg_chan_i == c_idx);

        always_comb begin
            period_d  = period_q;
            cnt_d     = cnt_q;
            en_d      = en_q;
            oneshot_d = oneshot_q;
            strobe_d  = 1'b0;
            if (wr) begin
                period_d  = cfg_period_i;
                cnt_d     = cfg_period_i;
                en_d      = cfg_en_i;
                oneshot_d = cfg_oneshot_i;
            end else if (en_q) begin
                if (sync_i) begin
                    cnt_d = period_q;
                end else if (cnt_q == '0) begin
                    cnt_d    = period_q;
                    strobe_d = 1'b1;
                    if (oneshot_q) begin
                        en_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                period_q  <= '0;
                cnt_q     <= '0;
                en_q      <= 1'b0;
                oneshot_q <= 1'b0;
                strobe_q  <= 1'b0;
            end else begin
                period_q  <= period_d;
                cnt_q     <= cnt_d;
                en_q      <= en_d;
                oneshot_q <= oneshot_d;
                strobe_q  <= strobe_d;
            end
        end

        assign strobe_r_o[g] = strobe_q;
        assign active_o[g]   = en_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_bsg_strobe_multi.sv
//------------------------------------------------------------------------------
// tb_bsg_strobe_multi : scoreboard bench with an event-time reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_strobe_multi;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int LG  = 3;

    logic           clk;
    logic           reset_n;
    logic           cfg_v;
    logic           cfg_ready;
    logic [LG-1:0]  cfg_chan;
    logic [W-1:0]   cfg_period;
    logic           cfg_en;
    logic           cfg_oneshot;
    logic           sync;
    logic [NCH-1:0] strobe;
    logic [NCH-1:0] active;

    bsg_strobe_multi #(
        .channels_p    (NCH),
        .width_p       (W),
        .lg_channels_lp(LG)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .cfg_v_i      (cfg_v),
        .cfg_ready_o  (cfg_ready),
        .cfg_chan_i   (cfg_chan),
        .cfg_period_i (cfg_period),
        .cfg_en_i     (cfg_en),
        .cfg_oneshot_i(cfg_oneshot),
        .sync_i       (sync),
        .strobe_r_o   (strobe),
        .active_o     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] s;
        logic [NCH-1:0] a;
    } exp_t;

    exp_t q_exp[$];
    int   tests  = 0;
    int   errors = 0;

    // Reference model: each enabled channel remembers the absolute edge
    // number at which its next strobe is due.
    int   edge_n = 0;
    bit   m_en[NCH];
    bit   m_os[NCH];
    int   m_per[NCH];
    int   m_next[NCH];

    task automatic cycle(input bit rst_n, input bit v, input int chan,
                         input int per, input bit en, input bit os, input bit sy);
        exp_t e;
        reset_n     = rst_n;
        cfg_v       = v;
        cfg_chan    = LG'(chan);
        cfg_period  = W'(per);
        cfg_en      = en;
        cfg_oneshot = os;
        sync        = sy;
        #1;
        tests++;
        if (cfg_ready !== rst_n) begin
            errors++;
            $display("FAIL cfg_ready edge %0d: got %b want %b", edge_n, cfg_ready, rst_n);
        end
        edge_n++;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                m_en[c] = 0; m_os[c] = 0; m_per[c] = 0;
            end else if (v && chan == c) begin
                m_en[c] = en; m_os[c] = os; m_per[c] = per;
                m_next[c] = edge_n + per + 1;
            end else if (m_en[c] && sy) begin
                m_next[c] = edge_n + m_per[c] + 1;
            end else if (m_en[c] && edge_n == m_next[c]) begin
                e.s[c] = 1'b1;
                m_next[c] = edge_n + m_per[c] + 1;
                if (m_os[c]) m_en[c] = 0;
            end
            e.a[c] = m_en[c];
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int chan, input int per, input bit en, input bit os);
        cycle(1, 1, chan, per, en, os, 0);
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            tests++;
            if (strobe !== e.s || active !== e.a) begin
                errors++;
                $display("FAIL outputs time %0t: strobe got %b want %b, active got %b want %b",
                         $time, strobe, e.s, active, e.a);
            end
        end
    end

    initial begin
        reset_n = 0; cfg_v = 0; cfg_chan = '0; cfg_period = '0;
        cfg_en = 0; cfg_oneshot = 0; sync = 0;
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_os[c] = 0; m_per[c] = 0; m_next[c] = 0;
        end

        rst(3);
        idle(100);

        wr(1, 4, 1, 0);
        idle(22);

        rst(1);
        wr(0, 3, 1, 1);
        idle(10);
        wr(2, 0, 1, 0);
        idle(6);

        // Rewrite landing on the edge where the counter reaches zero.
        rst(1);
        wr(1, 4, 1, 0);
        idle(4);
        wr(1, 2, 1, 0);
        idle(10);

        // Sync together with a write: the written channel takes the write.
        wr(0, 3, 1, 0);
        idle(2);
        cycle(1, 1, 1, 4, 1, 0, 1);
        idle(12);

        rst(1);
        wr(0, 5, 1, 0);
        idle(1);
        wr(3, 5, 1, 0);
        idle(15);
        cycle(1, 0, 0, 0, 0, 0, 1);
        idle(15);

        wr(0, 1, 1, 0); wr(1, 2, 1, 0); wr(2, 0, 1, 0); wr(3, 3, 1, 0);
        idle(5);
        rst(1);
        idle(20);

        wr(1, 3, 1, 0);
        wr(5, 2, 1, 0);
        idle(10);

        for (int i = 0; i < 4000; i++) begin
            bit rn, v, en, os, sy;
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 4) != 0);
            os = ($urandom_range(0, 3) == 0);
            sy = ($urandom_range(0, 39) == 0);
            cycle(rn, v, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), en, os, sy);
        end

        @(negedge clk);
        #1;
        tests++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

`default_nettype wire
